// File: rtl/wide_add_pkg.sv
// Shared types and sizing helpers for the wide add/subtract sequencer.
package wide_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

  // A single-slice build still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Operand/result handshake bundle between a requester and wide_add_seq.
interface wide_add_seq_if #(parameter int WIDTH = 256);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/wide_add_seq_add16_slice.sv
// Combinational 16-bit adder slice: pg generation, Kogge-Stone prefix carry, sum.
module add16_slice (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] g_acc;
  logic [15:0] p_acc;
  logic [15:0] g_nxt;
  logic [15:0] p_nxt;
  logic [16:0] carry;

  // Group (g,p) over bits [i:0] after log2(16) prefix levels.
  always_comb begin
    g_acc = a & b;
    p_acc = a ^ b;
    g_nxt = '0;
    p_nxt = '0;
    for (int d = 1; d < 16; d = d * 2) begin
      g_nxt = g_acc;
      p_nxt = p_acc;
      for (int i = d; i < 16; i++) begin
        g_nxt[i] = g_acc[i] | (p_acc[i] & g_acc[i-d]);
        p_nxt[i] = p_acc[i] & p_acc[i-d];
      end
      g_acc = g_nxt;
      p_acc = p_nxt;
    end
  end

  always_comb begin
    carry[0] = cin;
    for (int i = 0; i < 16; i++) begin
      carry[i+1] = g_acc[i] | (p_acc[i] & cin);
    end
  end

  assign s    = (a ^ b) ^ carry[15:0];
  assign cout = carry[16];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle WIDTH-bit add/subtract through one shared 16-bit slice, LS slice first.
// Subtraction is built only when WIDE_ADD_SUB_EN is defined; otherwise sub is ignored.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  wide_add_seq_if.slave bus
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic [WIDTH-1:0]   b_in;
  logic               cin_in;

`ifdef WIDE_ADD_SUB_EN
  assign b_in   = bus.sub ? ~bus.b : bus.b;
  assign cin_in = bus.sub;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_in       = bus.b;
  assign cin_in     = 1'b0;
`endif

  assign slice_a = op_a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b = op_b_q[idx_q*SLICE_W +: SLICE_W];

  add16_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_a_d     = bus.a;
          op_b_d     = b_in;
          carry_d    = cin_in;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        // The last slice's carry-out is the architectural cout.
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          cout_d      = slice_cout;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle wide adder/subtractor sequencer for the modular-multiplication datapath. It accepts two WIDTH-bit operands and streams them, one 16-bit slice per cycle, through a single 16-bit propagate/generate adder slice, least-significant slice first. The carry is chained between slices in a register. The block lets the reduction and accumulate stages share one narrow adder instead of instantiating a WIDTH-bit adder.

## Interface
- WIDTH, 256, operand/result width in bits; multiple of 16, minimum 16
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and mode valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  augend/minuend
- b  input  WIDTH  addend/subtrahend
- sub  input  1  1 = compute a - b (only with WIDE_ADD_SUB_EN)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b (or a - b) mod 2^WIDTH
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b)

## Operation
- NSLICE = WIDTH/16; slice index register width is clog2(NSLICE), minimum 1.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch a, b (b inverted if subtracting), carry = sub ? 1 : 0, idx = 0, go to RUN.
  - RUN: each cycle, adder slice adds opA[idx*16+:16] + opB[idx*16+:16] + carry. Write the 16-bit result into sum[idx*16+:16], register the slice carry-out, idx++. When idx == NSLICE-1, go to DONE.
  - DONE: out_valid=1, cout = final carry. On out_ready, go to IDLE.
- sum and cout are registered and stay stable throughout DONE. Bits are not cleared between operations; partially written slices are only visible while out_valid=0.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored.
- Arithmetic: add = a + b + 0; subtract = a + ~b + 1. Result truncated to WIDTH bits; overflow/borrow appears only on cout.
- Reset (any state, including mid-RUN):
  - Immediately returns to IDLE and aborts the in-flight operation without output.
  - sum=0, cout=0, out_valid=0, idx=0, carry=0, in_ready=1 while rst is low after release.

## Timing
- Accept at edge E0; RUN occupies the NSLICE cycles after E0; out_valid rises after edge E0+NSLICE.
- Latency from accept to out_valid: NSLICE cycles. WIDTH=16 gives 1 cycle; WIDTH=256 gives 16 cycles.
- The DONE-to-IDLE handshake costs one edge. Maximum throughput is one operation per NSLICE+2 cycles.
- Slice critical path: 16-bit pg generation + prefix carry + carry register mux. No WIDTH-wide carry path exists.

## Configuration
- WIDE_ADD_SUB_EN defined: sub input honoured, selecting b inversion and carry-in 1.
- WIDE_ADD_SUB_EN undefined: sub port still present but ignored; always adds, carry-in 0, no inversion logic synthesised.

## Structure
- Shared package wide_add_pkg:
  - SLICE_W = 16
  - FSM state enum (IDLE, RUN, DONE)
  - function nslice(width)
- One sub-module, add16_slice: combinational 16-bit pg generation, prefix carry network and sum. Inputs: a[15:0], b[15:0], cin. Outputs: s[15:0], cout. Instantiated once.

## Test plan
- WIDTH=64, add, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1 -> sum=0x0, cout=1, out_valid exactly 4 cycles after accept.
- WIDTH=64, add, a=0x0000_FFFF_FFFF_FFFF, b=0x1 -> sum=0x0001_0000_0000_0000, cout=0 (carry across three slice boundaries).
- WIDTH=64, sub=1 with WIDE_ADD_SUB_EN, a=5, b=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. Same with a=7, b=5 -> sum=2, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum/cout/out_valid stable, in_ready=0, a second in_valid ignored. out_ready=1 -> IDLE next edge, then second op accepted.
- Assert rst for 1 cycle at slice 2 of a 4-slice op -> out_valid never rises, sum=0, cout=0, in_ready=1 after release. New op a=3, b=4 -> sum=7.
- WIDTH=16 build: a=0x8000, b=0x8000 -> sum=0x0000, cout=1, out_valid 1 cycle after accept.
